// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: opcodes, ALU ops and the control-word layout.
package decode_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  localparam int unsigned CTRL_ALU_R    = 0;
  localparam int unsigned CTRL_ADDI     = 1;
  localparam int unsigned CTRL_LW       = 2;
  localparam int unsigned CTRL_SW       = 3;
  localparam int unsigned CTRL_J        = 4;
  localparam int unsigned CTRL_BNE      = 5;
  localparam int unsigned CTRL_JAL      = 6;
  localparam int unsigned CTRL_JR       = 7;
  localparam int unsigned CTRL_BLT      = 8;
  localparam int unsigned CTRL_BEX      = 9;
  localparam int unsigned CTRL_SETX     = 10;
  localparam int unsigned CTRL_ILLEGAL  = 11;
  localparam int unsigned CTRL_REG_WE   = 12;
  localparam int unsigned CTRL_USES_IMM = 13;
  localparam int unsigned N_CTRL        = 14;

  function automatic logic alu_op_legal(input logic [4:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction decoder: fields, immediates, register addresses and control word.
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LINK_REG   = 31,
  parameter int unsigned STATUS_REG = 30
) (
  input  logic [31:0]       instr,
  output logic [4:0]        opcode,
  output logic [4:0]        shamt,
  output logic [4:0]        aluop,
  output logic [4:0]        alu_sel,
  output logic [4:0]        rsrc_a,
  output logic [4:0]        rsrc_b,
  output logic [4:0]        rdst,
  output logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   target,
  output logic [N_CTRL-1:0] ctrl
);

  localparam logic [4:0] LinkAddr   = 5'(LINK_REG);
  localparam logic [4:0] StatusAddr = 5'(STATUS_REG);

  logic [4:0] f_rd;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic       reg_we;

  assign opcode = instr[31:27];
  assign f_rd   = instr[26:22];
  assign f_rs   = instr[21:17];
  assign f_rt   = instr[16:12];
  assign shamt  = instr[11:7];
  assign aluop  = instr[6:2];
  assign imm    = {{(XLEN-17){instr[16]}}, instr[16:0]};
  assign target = {{(XLEN-27){1'b0}}, instr[26:0]};

  always_comb begin
    rsrc_a  = 5'd0;
    rsrc_b  = 5'd0;
    rdst    = 5'd0;
    alu_sel = ALU_ADD;
    reg_we  = 1'b0;
    ctrl    = '0;
    case (opcode)
      OP_RTYPE: begin
        if (alu_op_legal(aluop)) begin
          ctrl[CTRL_ALU_R] = 1'b1;
          rsrc_a  = f_rs;
          rsrc_b  = f_rt;
          rdst    = f_rd;
          alu_sel = aluop;
          reg_we  = 1'b1;
        end else begin
          ctrl[CTRL_ILLEGAL] = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl[CTRL_ADDI]     = 1'b1;
        ctrl[CTRL_USES_IMM] = 1'b1;
        rsrc_a = f_rs;
        rdst   = f_rd;
        reg_we = 1'b1;
      end
      OP_LW: begin
        ctrl[CTRL_LW]       = 1'b1;
        ctrl[CTRL_USES_IMM] = 1'b1;
        rsrc_a = f_rs;
        rdst   = f_rd;
        reg_we = 1'b1;
      end
      OP_SW: begin
        ctrl[CTRL_SW]       = 1'b1;
        ctrl[CTRL_USES_IMM] = 1'b1;
        rsrc_a = f_rs;
        rsrc_b = f_rd;
      end
      OP_BNE, OP_BLT: begin
        ctrl[CTRL_BNE] = (opcode == OP_BNE);
        ctrl[CTRL_BLT] = (opcode == OP_BLT);
        rsrc_a  = f_rd;
        rsrc_b  = f_rs;
        alu_sel = ALU_SUB;
      end
      OP_J: ctrl[CTRL_J] = 1'b1;
      OP_JAL: begin
        ctrl[CTRL_JAL] = 1'b1;
        rdst   = LinkAddr;
        reg_we = 1'b1;
      end
      OP_JR: begin
        ctrl[CTRL_JR] = 1'b1;
        rsrc_a = f_rd;
      end
      OP_BEX: begin
        ctrl[CTRL_BEX] = 1'b1;
        rsrc_a = StatusAddr;
      end
      OP_SETX: begin
        ctrl[CTRL_SETX] = 1'b1;
        rdst   = StatusAddr;
        reg_we = 1'b1;
      end
      default: ctrl[CTRL_ILLEGAL] = 1'b1;
    endcase
    // r0 is hardwired, so a write to it is dropped here rather than in the regfile.
    ctrl[CTRL_REG_WE] = reg_we && (rdst != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, stall and flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned LINK_REG   = 31,
  parameter int unsigned STATUS_REG = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [4:0]        out_opcode,
  output logic [4:0]        out_shamt,
  output logic [4:0]        out_aluop,
  output logic [4:0]        out_alu_sel,
  output logic [4:0]        out_rsrc_a,
  output logic [4:0]        out_rsrc_b,
  output logic [4:0]        out_rdst,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_target,
  output logic [N_CTRL-1:0] out_ctrl
);

  logic [4:0]        opcode_d;
  logic [4:0]        shamt_d;
  logic [4:0]        aluop_d;
  logic [4:0]        alu_sel_d;
  logic [4:0]        rsrc_a_d;
  logic [4:0]        rsrc_b_d;
  logic [4:0]        rdst_d;
  logic [XLEN-1:0]   imm_d;
  logic [XLEN-1:0]   target_d;
  logic [N_CTRL-1:0] ctrl_d;
  logic              accept;

  decode_comb #(
    .XLEN       (XLEN),
    .LINK_REG   (LINK_REG),
    .STATUS_REG (STATUS_REG)
  ) u_decode_comb (
    .instr   (in_instr),
    .opcode  (opcode_d),
    .shamt   (shamt_d),
    .aluop   (aluop_d),
    .alu_sel (alu_sel_d),
    .rsrc_a  (rsrc_a_d),
    .rsrc_b  (rsrc_b_d),
    .rdst    (rdst_d),
    .imm     (imm_d),
    .target  (target_d),
    .ctrl    (ctrl_d)
  );

  // flush gates in_ready, so an accept can never coincide with a flush.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_shamt   <= '0;
      out_aluop   <= '0;
      out_alu_sel <= '0;
      out_rsrc_a  <= '0;
      out_rsrc_b  <= '0;
      out_rdst    <= '0;
      out_imm     <= '0;
      out_target  <= '0;
      out_ctrl    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_opcode  <= opcode_d;
      out_shamt   <= shamt_d;
      out_aluop   <= aluop_d;
      out_alu_sel <= alu_sel_d;
      out_rsrc_a  <= rsrc_a_d;
      out_rsrc_b  <= rsrc_b_d;
      out_rdst    <= rdst_d;
      out_imm     <= imm_d;
      out_target  <= target_d;
      out_ctrl    <= ctrl_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode table vectors plus stall/flush/reset sequences.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready64;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_valid64;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc64;
  logic [4:0]  out_opcode, out_shamt, out_aluop, out_alu_sel;
  logic [4:0]  out_rsrc_a, out_rsrc_b, out_rdst;
  logic [4:0]  o64_opcode, o64_shamt, o64_aluop, o64_alu_sel;
  logic [4:0]  o64_rsrc_a, o64_rsrc_b, o64_rdst;
  logic [31:0] out_imm, out_target;
  logic [63:0] o64_imm, o64_target;
  logic [13:0] out_ctrl, o64_ctrl;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  decode_stage #(.XLEN(32), .PC_W(32), .LINK_REG(31), .STATUS_REG(30)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_shamt(out_shamt), .out_aluop(out_aluop),
    .out_alu_sel(out_alu_sel), .out_rsrc_a(out_rsrc_a), .out_rsrc_b(out_rsrc_b),
    .out_rdst(out_rdst), .out_imm(out_imm), .out_target(out_target), .out_ctrl(out_ctrl)
  );

  decode_stage #(.XLEN(64), .PC_W(32), .LINK_REG(31), .STATUS_REG(30)) dut64 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .out_opcode(o64_opcode), .out_shamt(o64_shamt), .out_aluop(o64_aluop),
    .out_alu_sel(o64_alu_sel), .out_rsrc_a(o64_rsrc_a), .out_rsrc_b(o64_rsrc_b),
    .out_rdst(o64_rdst), .out_imm(o64_imm), .out_target(o64_target), .out_ctrl(o64_ctrl)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  op;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [4:0]  alu;
    logic [13:0] ctrl;
    logic [31:0] imm;
    logic [31:0] tgt;
  } vec_t;

  localparam int NVec = 15;
  vec_t vecs[NVec];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_payload(input string tag, input vec_t v, input logic [31:0] pc);
    logic [31:0] w;
    w = v.instr;
    chk({tag, ".pc"}, 64'(out_pc), 64'(pc));
    chk({tag, ".opcode"}, 64'(out_opcode), 64'(v.op));
    chk({tag, ".shamt"}, 64'(out_shamt), 64'(w[11:7]));
    chk({tag, ".aluop"}, 64'(out_aluop), 64'(w[6:2]));
    chk({tag, ".rsrc_a"}, 64'(out_rsrc_a), 64'(v.ra));
    chk({tag, ".rsrc_b"}, 64'(out_rsrc_b), 64'(v.rb));
    chk({tag, ".rdst"}, 64'(out_rdst), 64'(v.rd));
    chk({tag, ".alu_sel"}, 64'(out_alu_sel), 64'(v.alu));
    chk({tag, ".ctrl"}, 64'(out_ctrl), 64'(v.ctrl));
    chk({tag, ".imm"}, 64'(out_imm), 64'(v.imm));
    chk({tag, ".target"}, 64'(out_target), 64'(v.tgt));
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_pc    = 32'h0;
    out_ready = 1'b1;
  endtask

  initial begin
    // instr, opcode, rsrc_a, rsrc_b, rdst, alu_sel, ctrl, imm, target
    vecs[0]  = '{32'h00443000, 5'd0,  5'd2,  5'd3, 5'd1,  5'd0, 14'h1001, 32'h00003000, 32'h00443000};
    vecs[1]  = '{32'h290BFFFF, 5'd5,  5'd5,  5'd0, 5'd4,  5'd0, 14'h3002, 32'hFFFFFFFF, 32'h010BFFFF};
    vecs[2]  = '{32'h398E0008, 5'd7,  5'd7,  5'd6, 5'd0,  5'd0, 14'h2008, 32'h00000008, 32'h018E0008};
    vecs[3]  = '{32'h18000100, 5'd3,  5'd0,  5'd0, 5'd31, 5'd0, 14'h1040, 32'h00000100, 32'h00000100};
    vecs[4]  = '{32'hF8000000, 5'd31, 5'd0,  5'd0, 5'd0,  5'd0, 14'h0800, 32'h00000000, 32'h00000000};
    vecs[5]  = '{32'h00022000, 5'd0,  5'd1,  5'd2, 5'd0,  5'd0, 14'h0001, 32'h00002000, 32'h00022000};
    vecs[6]  = '{32'h10440004, 5'd2,  5'd1,  5'd2, 5'd0,  5'd1, 14'h0020, 32'h00000004, 32'h00440004};
    vecs[7]  = '{32'hA8000005, 5'd21, 5'd0,  5'd0, 5'd30, 5'd0, 14'h1400, 32'h00000005, 32'h00000005};
    vecs[8]  = '{32'hB0000007, 5'd22, 5'd30, 5'd0, 5'd0,  5'd0, 14'h0200, 32'h00000007, 32'h00000007};
    vecs[9]  = '{32'h00443018, 5'd0,  5'd0,  5'd0, 5'd0,  5'd0, 14'h0800, 32'h00003018, 32'h00443018};
    vecs[10] = '{32'h4212000C, 5'd8,  5'd9,  5'd0, 5'd8,  5'd0, 14'h3004, 32'h0000000C, 32'h0212000C};
    vecs[11] = '{32'h00443214, 5'd0,  5'd2,  5'd3, 5'd1,  5'd5, 14'h1001, 32'h00003214, 32'h00443214};
    vecs[12] = '{32'h30C80010, 5'd6,  5'd3,  5'd4, 5'd0,  5'd1, 14'h0100, 32'h00000010, 32'h00C80010};
    vecs[13] = '{32'h08000040, 5'd1,  5'd0,  5'd0, 5'd0,  5'd0, 14'h0010, 32'h00000040, 32'h00000040};
    vecs[14] = '{32'h21400000, 5'd4,  5'd5,  5'd0, 5'd0,  5'd0, 14'h0080, 32'h00000000, 32'h01400000};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.ctrl", 64'(out_ctrl), 64'd0);
    chk("reset.imm", 64'(out_imm), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Decode table, one accepted instruction per vector.
    for (int i = 0; i < NVec; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(i * 4);
      #1;
      chk($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'd1);
      chk_payload($sformatf("v%0d", i), vecs[i], 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d.imm64", i), o64_imm, {{32{vecs[i].imm[31]}}, vecs[i].imm});
      chk($sformatf("v%0d.target64", i), o64_target, {32'h0, vecs[i].tgt});
    end
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    // Stall: A accepted, B waits three cycles behind out_ready = 0.
    @(negedge clock);
    in_valid = 1'b1;
    in_instr = vecs[0].instr;
    in_pc    = 32'h2000;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    in_instr  = vecs[3].instr;
    in_pc     = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) begin
        @(posedge clock);
        #1;
      end else begin
        #1;
      end
      chk($sformatf("stall%0d.in_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d.out_valid", c), 64'(out_valid), 64'd1);
      chk_payload($sformatf("stall%0d", c), vecs[0], 32'h2000);
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    chk("release.out_valid", 64'(out_valid), 64'd1);
    chk_payload("release", vecs[3], 32'h2004);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("nodup.out_valid", 64'(out_valid), 64'd0);

    // Flush while holding C with D offered: D must not be consumed.
    @(negedge clock);
    in_valid  = 1'b1;
    in_instr  = vecs[2].instr;
    in_pc     = 32'h3000;
    out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    flush    = 1'b1;
    in_instr = vecs[1].instr;
    in_pc    = 32'h3004;
    #1;
    chk("flush.in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk_payload("flush.kept", vecs[2], 32'h3000);
    @(negedge clock);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("flush.not_consumed", 64'(out_valid), 64'd0);
    chk("flush.pc_unchanged", 64'(out_pc), 64'h3000);

    // Reset mid-stall drops the held instruction and clears the payload.
    @(negedge clock);
    in_valid  = 1'b1;
    in_instr  = vecs[10].instr;
    in_pc     = 32'h4000;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("prereset.out_valid", 64'(out_valid), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    chk("midreset.out_valid", 64'(out_valid), 64'd0);
    chk("midreset.pc", 64'(out_pc), 64'd0);
    chk("midreset.rsrc_a", 64'(out_rsrc_a), 64'd0);
    chk("midreset.rdst", 64'(out_rdst), 64'd0);
    chk("midreset.ctrl", 64'(out_ctrl), 64'd0);
    chk("midreset.imm", 64'(out_imm), 64'd0);
    chk("midreset.target", 64'(out_target), 64'd0);
    chk("midreset.opcode", 64'(out_opcode), 64'd0);
    chk("midreset.imm64", o64_imm, 64'd0);
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
